// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - byte-serial UART transmitter, 8 data bits, optional even parity, 1 stop bit
// Bytes are accepted on a valid/ready handshake while idle and shifted out LSB first on o_txd.
module uart_tx_byte #(
   parameter int BAUD_DIV  = 868,
   parameter int PARITY_EN = 0
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_txd,
   output logic       o_busy,
   output logic       o_done
);

   localparam int            CW     = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    idx, idx_n;
   logic [7:0]    shreg, shreg_n;
   logic          txd_n;
   logic          done_n;
   logic          bit_end;

   assign o_ready = (state == IDLE);
   assign bit_end = (cnt == '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= IDLE;
         cnt    <= '0;
         idx    <= '0;
         shreg  <= '0;
         o_txd  <= 1'b1;
         o_busy <= 1'b0;
         o_done <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         idx    <= idx_n;
         shreg  <= shreg_n;
         o_txd  <= txd_n;
         o_busy <= (state_n != IDLE);
         o_done <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      shreg_n = shreg;
      done_n  = 1'b0;
      txd_n   = 1'b1;

      case (state)
         IDLE: begin
            if (i_valid) begin
               state_n = START;
               cnt_n   = RELOAD;
               shreg_n = i_data;
            end
         end
         START: begin
            if (bit_end) begin
               state_n = DATA;
               cnt_n   = RELOAD;
               idx_n   = 3'd0;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_n = RELOAD;
               if (idx == 3'd7) begin
                  state_n = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  idx_n = idx + 3'd1;
               end
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_n = STOP;
               cnt_n   = RELOAD;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // Line level is registered, so it is derived from where the FSM is going next.
      case (state_n)
         START:   txd_n = 1'b0;
         DATA:    txd_n = shreg_n[idx_n];
         PARITY:  txd_n = ^shreg_n;
         default: txd_n = 1'b1;
      endcase
   end

endmodule

// File: doc/uart_tx_byte.md
# uart_tx_byte

Byte-serial UART transmitter, 8 data bits, 1 stop bit, optional even parity. It sits directly downstream of the top-level design logic (100 MHz system clock domain) and turns bytes presented on a valid/ready handshake into a serial line on the board's UART TX pin. A `o_done` pulse per frame lets the producer count or pace frames.

## Interface
Parameters:
- `BAUD_DIV`, default 868. Clocks per bit (100 MHz / 115200, truncated). Legal range is 2..65535.
- `PARITY_EN`, default 0. 0 gives 8N1. 1 gives 8E1: an even parity bit is inserted after data bit 7.

Ports:
- `i_clk`, input, 1 bit. System clock, 100 MHz.
- `i_rst`, input, 1 bit. Reset, synchronous and active-high. It has priority over all other inputs.
- `i_data`, input, 8 bits. Byte to transmit. Sampled only on handshake.
- `i_valid`, input, 1 bit. Producer has a byte.
- `o_ready`, output, 1 bit. Transmitter idle and able to accept a byte. Equals (state == IDLE), combinational.
- `o_txd`, output, 1 bit. Serial line, registered, idle high.
- `o_busy`, output, 1 bit. Frame in progress. Registered; equals !o_ready.
- `o_done`, output, 1 bit. One-cycle pulse marking frame completion.

## Operation
- There is one clock and one reset: synchronous, active-high `i_rst`. The clock is `i_clk`.
- States:
  - IDLE → START on handshake, i.e. `i_valid && o_ready` at a rising edge with `i_rst = 0`. `i_data` is latched into a shift register at that edge.
  - START → DATA after BAUD_DIV clocks.
  - DATA → PARITY (if PARITY_EN) or STOP after 8 bits.
  - PARITY → STOP after BAUD_DIV clocks.
  - STOP → IDLE after BAUD_DIV clocks.
- Line levels per state:
  - START: `o_txd` = 0.
  - DATA: `o_txd` = current bit, LSB first.
  - PARITY: `o_txd` = XOR of the 8 latched bits.
  - STOP and IDLE: `o_txd` = 1.
- Bit timing: a down-counter of width clog2(BAUD_DIV) is reloaded with BAUD_DIV-1 on each bit entry. The bit ends when the counter reaches 0. A 3-bit index selects the data bit.
- Changes on `i_data` or `i_valid` after the handshake are ignored until the next IDLE.
- `o_done` is asserted for exactly one cycle, the first IDLE cycle after STOP.
- Reset values: state IDLE, `o_txd` = 1, `o_busy` = 0, `o_done` = 0, counters 0. `o_ready` reads 1 after the reset edge.
- While `i_rst` = 1, `i_valid` is ignored and no handshake occurs.
- Reset mid-frame aborts the frame. `o_txd` = 1 from the next edge, with no `o_done` pulse and no partial resume.
- `i_valid` high during the `o_done` cycle is accepted at that cycle's closing edge (back-to-back frames).

## Timing
- Handshake at edge T: `o_txd` = 0 and `o_busy` = 1 from T+1.
- Bit k (0 = start) occupies cycles T+1+k·BAUD_DIV … T+(k+1)·BAUD_DIV.
- Frame length: 10·BAUD_DIV clocks (8N1) or 11·BAUD_DIV clocks (8E1).
- `o_done` = 1 and `o_ready` = 1 in cycle T+1+10·BAUD_DIV (8N1).
- Minimum handshake-to-handshake period: 10·BAUD_DIV+1 clocks (11·BAUD_DIV+1 with parity). This leaves one idle-high cycle between back-to-back frames.
- Latency from handshake to first line transition: 1 clock.
- No combinational path from `i_valid` to `o_ready`.

## Test plan
- Reset check: hold `i_rst` = 1 for 10 cycles with `i_valid` = 1 → `o_txd` = 1, `o_busy` = 0, `o_done` = 0 throughout. `o_ready` = 1 after release, and no frame starts during reset.
- Default 8N1 with BAUD_DIV = 868: send 0x55 → line reads 0,1,0,1,0,1,0,1,0,1, each level exactly 868 clocks. `o_done` pulses once at 8681 clocks after the handshake.
- Parity with BAUD_DIV = 4 and PARITY_EN = 1:
  - send 0x07 → bits 0,1,1,1,0,0,0,0,0, parity 1, stop 1. Frame is 44 clocks.
  - send 0x03 → parity bit 0.
- Back-to-back with BAUD_DIV = 4: hold `i_valid` = 1 with 0xA5 then 0x3C → second start bit begins exactly 41 clocks after the first. Exactly one idle-high cycle separates the frames, and two `o_done` pulses occur.
- Mid-frame reset with BAUD_DIV = 4: assert `i_rst` for 1 cycle during data bit 3 of 0x00 → `o_txd` = 1 on the following edge, no `o_done`. A subsequent 0xFF frame is clean (start 0, eight 1s, stop 1).
- Data stability, BAUD_DIV = 2: change `i_data` every cycle after handshake of 0x81 → transmitted bits remain 1,0,0,0,0,0,0,1 (LSB first).
